// File: rtl/nn_pkg.sv
// Shared constants and data type for the network datapath.
// Every layer-stage module imports this package.
package nn_pkg;

    localparam int NN_M = 13;
    localparam int NN_T = 32;

    typedef logic signed [NN_T-1:0] nn_data_t;

endpackage

// File: rtl/nn_argmax_stage.sv
// Classification tail: streams M signed values per vector and emits the index and value
// of the largest element. Ties keep the lowest index.
module nn_argmax_stage
    import nn_pkg::*;
#(
    parameter int M = NN_M,
    parameter int T = NN_T
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [T-1:0] data_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [$clog2(M)-1:0] idx_out,
    output logic signed [T-1:0] max_out
);

    localparam int IW = $clog2(M);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    logic [IW-1:0]        cnt_q, cnt_d;
    logic signed [T-1:0]  best_val_q, best_val_d;
    logic [IW-1:0]        best_idx_q, best_idx_d;
    logic                 m_valid_q, m_valid_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [T-1:0]  max_q, max_d;

    logic                 in_xfer;
    logic                 is_last;
    logic                 take;
    logic signed [T-1:0]  cand_val;
    logic [IW-1:0]        cand_idx;

    // Only the closing element of a vector must wait for room in the output register.
    assign s_ready = (cnt_q != LAST_IDX) || !m_valid_q || m_ready;

    always_comb begin
        in_xfer    = s_valid && s_ready;
        is_last    = (cnt_q == LAST_IDX);
        take       = (cnt_q == '0) || (data_in > best_val_q);
        cand_val   = take ? data_in : best_val_q;
        cand_idx   = take ? cnt_q : best_idx_q;

        cnt_d      = cnt_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        m_valid_d  = m_valid_q;
        idx_d      = idx_q;
        max_d      = max_q;

        if (in_xfer) begin
            best_val_d = cand_val;
            best_idx_d = cand_idx;
            cnt_d      = is_last ? '0 : cnt_q + 1'b1;
        end

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // A freshly completed vector overrides the drain, so back-to-back results have no bubble.
        if (in_xfer && is_last) begin
            m_valid_d = 1'b1;
            idx_d     = cand_idx;
            max_d     = cand_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            m_valid_q  <= 1'b0;
            idx_q      <= '0;
            max_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            m_valid_q  <= m_valid_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
        end
    end

    assign m_valid = m_valid_q;
    assign idx_out = idx_q;
    assign max_out = max_q;

endmodule

// File: tb/tb_nn_argmax_stage.sv
// Self-checking bench for nn_argmax_stage: directed vectors, back-pressure, reset
// mid-vector and a long random run scored against a queue-based argmax model.
module tb_nn_argmax_stage;

    localparam int M = 13;
    localparam int T = 32;

    typedef logic signed [T-1:0] vec_t [M];
    typedef struct {
        logic [3:0]  idx;
        logic [31:0] val;
    } res_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [T-1:0] data_in = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [3:0]          idx_out;
    logic signed [T-1:0] max_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int popped = 0;
    int ready_mode = 2;
    logic [3:0]  last_idx;
    logic [31:0] last_max;

    logic signed [T-1:0] cur_q[$];
    res_t exp_q[$];

    nn_argmax_stage #(.M(M), .T(T)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .data_in (data_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .idx_out (idx_out),
        .max_out (max_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_argmax(input vec_t v);
        int bi = 0;
        res_t r;
        for (int i = 1; i < M; i++) begin
            if (v[i] > v[bi]) bi = i;
        end
        r.idx = 4'(bi);
        r.val = v[bi];
        return r;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7fff_ffff;
            default: return 32'($urandom_range(0, 15)) - 32'd8;
        endcase
    endfunction

    // m_ready driver: 0 = hold low, 1 = hold high, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    // Scoreboard: check outputs against the model state, then advance the model with the
    // handshakes that will complete at the coming rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            cur_q.delete();
            exp_q.delete();
        end else begin
            checkOutput("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                checkOutput("idx_out", 32'(idx_out), 32'(exp_q[0].idx));
                checkOutput("max_out", max_out, exp_q[0].val);
            end
            checkOutput("s_ready", 32'(s_ready),
                        32'((cur_q.size() != M - 1) || (exp_q.size() == 0) || m_ready));
            if (m_valid && m_ready && exp_q.size() != 0) begin
                last_idx = exp_q[0].idx;
                last_max = exp_q[0].val;
                popped++;
                void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                cur_q.push_back(data_in);
                if (cur_q.size() == M) begin
                    vec_t v;
                    for (int i = 0; i < M; i++) v[i] = cur_q[i];
                    exp_q.push_back(ref_argmax(v));
                    cur_q.delete();
                end
            end
        end
    end

    // Drives the first n elements of v; leaves s_valid high so calls chain without bubbles.
    task automatic applyStimulus(input vec_t v, input int n, input int gap_pct,
                                 output int stall_cycles, output int stall_elem);
        int guard;
        logic acc;
        stall_cycles = 0;
        stall_elem = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            while ($urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
                data_in = $urandom;
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            data_in = v[i];
            guard = 0;
            forever begin
                @(negedge clk);
                acc = s_ready;
                if (acc) break;
                stall_cycles++;
                stall_elem = i;
                guard++;
                if (guard > 500) begin
                    checkOutput("s_ready_timeout", 32'(acc), 32'd1);
                    break;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        data_in = $urandom;
    endtask

    task automatic waitPops(input int target);
        int guard = 0;
        while (popped < target && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("result_count", 32'(popped), 32'(target));
    endtask

    task automatic directed(input string name, input vec_t v, input logic [3:0] exp_idx,
                            input logic [31:0] exp_max);
        int st, se;
        res_t r;
        int target;
        r = ref_argmax(v);
        checkOutput({name, "_model_idx"}, 32'(r.idx), 32'(exp_idx));
        checkOutput({name, "_model_max"}, r.val, exp_max);
        target = popped + 1;
        applyStimulus(v, M, 30, st, se);
        idle();
        waitPops(target);
        checkOutput({name, "_dut_idx"}, 32'(last_idx), 32'(exp_idx));
        checkOutput({name, "_dut_max"}, last_max, exp_max);
    endtask

    initial begin
        vec_t v, v2;
        int st1, se1, st2, se2, target, t0, total_stall;

        #2 reset = 1'b0;
        #1;
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_idx_out", 32'(idx_out), 32'd0);
        checkOutput("reset_max_out", max_out, 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
        #19 reset = 1'b1;

        ready_mode = 2;
        for (int i = 0; i < M; i++) v[i] = i;
        directed("ascending", v, 4'd12, 32'd12);

        for (int i = 0; i < M; i++) v[i] = -5;
        directed("all_equal", v, 4'd0, 32'hffff_fffb);

        for (int i = 0; i < M; i++) v[i] = 32'sh8000_0000;
        v[7] = -1;
        directed("min_except_7", v, 4'd7, 32'hffff_ffff);

        for (int i = 0; i < M; i++) v[i] = -i;
        v[0] = 100;
        directed("max_first", v, 4'd0, 32'd100);

        // Back-pressure: two vectors offered while the sink is blocked for 40 cycles.
        ready_mode = 1;
        idle();
        repeat (3) @(posedge clk);
        for (int i = 0; i < M; i++) begin
            v[i]  = 32'(i * 7 % 13) - 6;
            v2[i] = 32'(i * 5 % 13) + 20;
        end
        target = popped + 2;
        fork
            begin
                applyStimulus(v, M, 0, st1, se1);
                applyStimulus(v2, M, 0, st2, se2);
            end
            begin
                ready_mode = 0;
                repeat (40) @(posedge clk);
                ready_mode = 1;
            end
        join
        idle();
        waitPops(target);
        checkOutput("bp_vec1_stalls", 32'(st1), 32'd0);
        checkOutput("bp_vec2_stall_elem", 32'(se2), 32'd12);
        checkOutput("bp_vec2_stalled", 32'(st2 > 0), 32'd1);

        // Throughput: continuous valid/ready must sustain one value per cycle.
        ready_mode = 1;
        idle();
        total_stall = 0;
        t0 = cyc;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < M; i++) v[i] = rand_val();
            applyStimulus(v, M, 0, st1, se1);
            total_stall += st1;
        end
        checkOutput("tput_cycles", 32'(cyc - t0), 32'(8 * M));
        checkOutput("tput_stalls", 32'(total_stall), 32'd0);
        idle();
        waitPops(popped + exp_q.size());

        // Reset with a pending result and a partial vector in flight.
        ready_mode = 0;
        for (int i = 0; i < M; i++) v[i] = rand_val();
        applyStimulus(v, M, 0, st1, se1);
        applyStimulus(v, 6, 0, st1, se1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_mid_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_mid_s_ready", 32'(s_ready), 32'd1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        ready_mode = 1;
        for (int i = 0; i < M; i++) v[i] = 32'(i * 3) - 10;
        v[3] = 99;
        target = popped + 1;
        applyStimulus(v, M, 0, st1, se1);
        idle();
        waitPops(target);
        checkOutput("rst_after_idx", 32'(last_idx), 32'd3);
        checkOutput("rst_after_max", last_max, 32'd99);

        // Long random run against the scoreboard.
        ready_mode = 2;
        target = popped + 1000;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < M; i++) v[i] = rand_val();
            applyStimulus(v, M, 25, st1, se1);
        end
        idle();
        ready_mode = 1;
        waitPops(target);
        checkOutput("final_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
